// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line/parity constants
// common to the TX serializer and the RX parity checker.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // Bit-counter width; a one-bit payload still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side of the UART transmitter plus its serial/busy status.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/par_calc.sv
// Registered parity generator; same equation as the RX parity checker so
// both ends of the link agree on even/odd polarity.
module par_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic                  typ);
    if (typ == PAR_EVEN) return ^d;
    else                 return ~^d;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)    par_bit <= 1'b0;
    else if (en) par_bit <= calc_parity(data, par_typ);
  end

endmodule

// File: rtl/uart_tx.sv
// UART serializer: start bit, LSB-first payload, optional parity, stop bit,
// one bit per clock; a new request may be accepted during the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  tx
);

  localparam int                CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit;
  logic                  accept;
  logic                  tx_nxt, busy_nxt;
  logic                  tx_q, busy_q;

  assign accept = tx.Data_Valid && ((state == IDLE) || (state == STOP));

  // Request capture: inputs are don't-care once the frame has started
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q   <= '0;
      par_en_q <= 1'b0;
    end else if (accept) begin
      data_q   <= tx.P_DATA;
      par_en_q <= tx.PAR_EN;
    end
  end

  par_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_par_calc (
    .CLK     (CLK),
    .RST     (RST),
    .en      (accept),
    .data    (tx.P_DATA),
    .par_typ (tx.PAR_TYP),
    .par_bit (par_bit)
  );

  // State register and bit counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter only advances inside DATA and never wraps
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE:   if (accept) state_nxt = START;
      START:  state_nxt = DATA;
      DATA: begin
        if (cnt == LAST) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PARITY: state_nxt = STOP;
      STOP:   state_nxt = accept ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the line value lands in a flop
  always_comb begin
    tx_nxt   = STOP_BIT;
    busy_nxt = 1'b1;
    case (state_nxt)
      IDLE:    busy_nxt = 1'b0;
      START:   tx_nxt   = START_BIT;
      DATA:    tx_nxt   = data_q[cnt_nxt];
      PARITY:  tx_nxt   = par_bit;
      STOP:    tx_nxt   = STOP_BIT;
      default: busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_q   <= STOP_BIT;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= tx_nxt;
      busy_q <= busy_nxt;
    end
  end

  assign tx.TX_OUT = tx_q;
  assign tx.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table-driven frames, corner-case sequences and a
// behavioural receiver fed from a scoreboard queue.
module tb_uart_tx;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(W)) bus ();

  uart_tx #(.DATA_WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .tx  (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
  } frame_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       exp_par;
    int         len;
  } vec_t;

  frame_t sb_q[$];
  vec_t   vecs[4];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Parity from a ones count: even-parity bit is 1 when the count is odd
  function automatic logic ref_par(input logic [7:0] d, input logic pt);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return ((n % 2) == 1) ^ pt;
  endfunction

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    frame_t f;
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    f.d = d; f.pe = pe; f.pt = pt;
    sb_q.push_back(f);
    @(posedge clk);
    #1 bus.Data_Valid = 1'b0;
  endtask

  // mode 0: plain; 1: disturb inputs mid-frame; 2: chain next frame at STOP
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic exp_par,
                             input int len, input int mode, input logic [7:0] nxt);
    logic exp_bit;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0)                       exp_bit = 1'b0;
      else if (i <= W)                  exp_bit = d[i-1];
      else if (pe && (i == W + 1))      exp_bit = exp_par;
      else                              exp_bit = 1'b1;
      chk($sformatf("tx bit %0d of frame %02h", i, d), bus.TX_OUT, exp_bit);
      chk($sformatf("busy bit %0d of frame %02h", i, d), bus.Busy, 1'b1);
      if (mode == 1) begin
        bus.P_DATA     = ~bus.P_DATA;
        bus.PAR_EN     = ~bus.PAR_EN;
        bus.PAR_TYP    = ~bus.PAR_TYP;
        bus.Data_Valid = (i == 4);
        if (i == 4) bus.P_DATA = 8'hFF;
      end
      if (mode == 2 && i == len - 1) start_frame(nxt, 1'b0, 1'b0);
    end
    bus.Data_Valid = 1'b0;
    if (mode != 2) begin
      @(negedge clk);
      chk($sformatf("idle line after %02h", d), bus.TX_OUT, 1'b1);
      chk($sformatf("busy low after %02h", d), bus.Busy, 1'b0);
    end
  endtask

  // Behavioural receiver: pops the expected frame on each start bit
  int         ph = 0;
  int         bi = 0;
  logic [7:0] sh;
  logic       rpar;
  frame_t     cur;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      ph = 0;
    end else begin
      case (ph)
        0: if (bus.TX_OUT == 1'b0) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx frame: got start bit, expected idle line (t=%0t)", $time);
          end else begin
            cur = sb_q.pop_front();
            ph  = 1;
            bi  = 0;
          end
        end
        1: begin
          sh[bi] = bus.TX_OUT;
          bi++;
          if (bi == W) ph = cur.pe ? 2 : 3;
        end
        2: begin
          rpar = bus.TX_OUT;
          ph   = 3;
        end
        default: begin
          chk("rx stop bit", bus.TX_OUT, 1'b1);
          chk("rx data", sh, cur.d);
          if (cur.pe) chk("rx parity error", (rpar != ref_par(sh, cur.pt)), 1'b0);
          ph = 0;
        end
      endcase
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       pe, pt;
    int         waited;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 11};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 11};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1, 11};

    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset tx_out", bus.TX_OUT, 1'b1);
    chk("reset busy", bus.Busy, 1'b0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle tx_out", bus.TX_OUT, 1'b1);
    chk("idle busy", bus.Busy, 1'b0);

    foreach (vecs[k]) begin
      start_frame(vecs[k].d, vecs[k].pe, vecs[k].pt);
      check_frame(vecs[k].d, vecs[k].pe, vecs[k].exp_par, vecs[k].len, 0, 8'h00);
    end

    // Dropped request and toggling inputs mid-frame
    start_frame(8'h5A, 1'b1, 1'b1);
    check_frame(8'h5A, 1'b1, 1'b1, 11, 1, 8'h00);

    // Back-to-back frames with no idle gap
    start_frame(8'h11, 1'b0, 1'b0);
    check_frame(8'h11, 1'b0, 1'b0, 10, 2, 8'h3C);
    check_frame(8'h3C, 1'b0, 1'b0, 10, 0, 8'h00);

    // Reset during data bit 5 of a parity frame, then accept on first edge
    start_frame(8'hC3, 1'b1, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset tx_out", bus.TX_OUT, 1'b1);
    chk("async reset busy", bus.Busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("held reset tx_out", bus.TX_OUT, 1'b1);
    chk("held reset busy", bus.Busy, 1'b0);
    #1 rst_n = 1'b1;
    start_frame(8'h81, 1'b1, 1'b0);
    check_frame(8'h81, 1'b1, 1'b0, 11, 0, 8'h00);

    // Loopback through the receiver model, frames chained at each STOP
    for (int k = 0; k < 256; k++) begin
      d  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      start_frame(d, pe, pt);
      repeat (pe ? 11 : 10) @(negedge clk);
    end
    waited = 0;
    while (bus.Busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("loopback drain busy", bus.Busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("scoreboard empty", sb_q.size(), 0);
    chk("rx idle at end", ph, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
